// File: rtl/uart_tx_io_if.sv
// uart_tx_io_if: core data-bus port bundle for the UART TX responder.
// The master drives address/strobes/write data; the slave returns read data.
interface uart_tx_io_if;
    logic [3:0]  addr_i;
    logic        cs_i;
    logic [31:0] data_i;
    logic        wr_i;
    logic        rd_i;
    logic [31:0] data_o;
    logic        data_rdy_o;

    modport master (
        output addr_i,
        output cs_i,
        output data_i,
        output wr_i,
        output rd_i,
        input  data_o,
        input  data_rdy_o
    );

    modport slave (
        input  addr_i,
        input  cs_i,
        input  data_i,
        input  wr_i,
        input  rd_i,
        output data_o,
        output data_rdy_o
    );
endinterface

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped UART transmitter with TX FIFO, 8N1 serialiser and irq.
// Optional even-parity bit (CTRL[2]) when UART_TX_PARITY_EN is defined.
module uart_tx_io #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int DEFAULT_DIV     = 139
) (
    input  logic         clk_i,
    input  logic         rst_i,
    uart_tx_io_if.slave  bus,
    output logic         txd_o,
    output logic         int_o,
    input  logic         int_ack_i
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int PW    = FIFO_DEPTH_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
`ifdef UART_TX_PARITY_EN
    logic        par_en_q, par_en_d;
    logic        par_bit_q, par_bit_d;
`endif

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    logic [15:0]   baud_q;
    logic [2:0]    ctrl_q;
    logic          int_q;
    logic [31:0]   rdata_q;
    logic          rdy_q;

    logic        acc_wr, acc_rd;
    logic [1:0]  sel;
    logic        push, push_ok, pop;
    logic        full, empty, busy, tick;
    logic        frame_done, txd;
    logic        tx_en, int_en;
    logic [31:0] status, rdata;
    logic [7:0]  head;

    assign acc_wr  = bus.cs_i & bus.wr_i;
    assign acc_rd  = bus.cs_i & bus.rd_i;
    assign sel     = bus.addr_i[3:2];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = acc_wr & (sel == 2'd0);
    assign push_ok = push & ~full;
    assign busy    = (state_q != ST_IDLE);
    assign tick    = (cnt_q == div_q - 16'd1);
    assign tx_en   = ctrl_q[0];
    assign int_en  = ctrl_q[1];
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // serialiser: one bit per div_q cycles, baud latched at frame start
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        pop        = 1'b0;
        txd        = 1'b1;
        frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = head;
                    div_d   = (baud_q == 16'd0) ? 16'd1 : baud_q;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = ctrl_q[2];
                    par_bit_d = ^head;
`endif
                end
            end
            ST_START: begin
                txd = 1'b0;
                if (tick) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                txd = sh_q[0];
                if (tick) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd = par_bit_q;
                if (tick) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                txd = 1'b1;
                if (tick) begin
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign txd_o = txd;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 16'd1;
            bit_q   <= '0;
            sh_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.data_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && full) begin
                ovf_q <= 1'b1;
            end else if (acc_wr && sel == 2'd1 && bus.data_i[3]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            baud_q <= 16'(DEFAULT_DIV);
            ctrl_q <= '0;
        end else if (acc_wr) begin
            if (sel == 2'd2) begin
                baud_q <= bus.data_i[15:0];
            end
            if (sel == 2'd3) begin
`ifdef UART_TX_PARITY_EN
                ctrl_q <= bus.data_i[2:0];
`else
                ctrl_q <= {1'b0, bus.data_i[1:0]};
`endif
            end
        end
    end

    // a new set beats a same-cycle acknowledge
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            int_q <= 1'b0;
        end else if (frame_done && int_en && empty) begin
            int_q <= 1'b1;
        end else if (int_ack_i) begin
            int_q <= 1'b0;
        end
    end

    assign int_o = int_q;

    always_comb begin
        status       = '0;
        status[0]    = busy;
        status[1]    = full;
        status[2]    = empty;
        status[3]    = ovf_q;
        status[12:8] = 5'(count_q);
    end

    always_comb begin
        rdata = '0;
        unique case (sel)
            2'd0: rdata = '0;
            2'd1: rdata = status;
            2'd2: rdata = {16'd0, baud_q};
            2'd3: rdata = {29'd0, ctrl_q};
            default: rdata = '0;
        endcase
    end

    // read data reflects pre-write register values
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdata_q <= acc_rd ? rdata : 32'd0;
            rdy_q   <= acc_rd;
        end
    end

    assign bus.data_o     = rdata_q;
    assign bus.data_rdy_o = rdy_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: scoreboard bench for uart_tx_io (register reads + serial frames).
// Define UART_TX_PARITY_EN for both bench and RTL to cover the parity build.
module tb_uart_tx_io;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic txd;
    logic intr;
    logic ack;

    uart_tx_io_if bus();

    uart_tx_io dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .bus       (bus),
        .txd_o     (txd),
        .int_o     (intr),
        .int_ack_i (ack)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    int          start_cyc[$];

    int tb_div   = 4;
    bit tb_par   = 0;
    bit mon_en   = 0;
    bit mon_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // read-data monitor
    always @(negedge clk) begin
        if (bus.data_rdy_o === 1'b1) begin
            if (exp_rd.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got data_rdy_o=1 data %h expected no read",
                         bus.data_o);
            end else begin
                check("rd_data", bus.data_o, exp_rd.pop_front());
            end
        end else if (bus.data_o !== 32'd0) begin
            check("rd_idle_zero", bus.data_o, 32'd0);
        end
    end

    // serial monitor: cycle-exact compare of each frame plus one idle cycle
    initial begin : tx_mon
        logic [7:0]  b;
        logic [10:0] bits;
        int          nb;
        bit          bad;
        int          badi;
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                mon_busy = 1;
                start_cyc.push_back(cyc);
                if (exp_tx.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got start bit expected idle line");
                    b = 8'h00;
                end else begin
                    b = exp_tx.pop_front();
                end
                bits      = '1;
                bits[0]   = 1'b0;
                bits[8:1] = b;
                if (tb_par) begin
                    bits[9] = ^b;
                    nb      = 11;
                end else begin
                    nb = 10;
                end
                bad  = 0;
                badi = 0;
                for (int i = 0; i < nb; i++) begin
                    for (int k = 0; k < tb_div; k++) begin
                        if (i != 0 || k != 0) @(negedge clk);
                        if (txd !== bits[i] && !bad) begin
                            bad  = 1;
                            badi = i;
                        end
                    end
                end
                @(negedge clk);
                if (txd !== 1'b1 && !bad) begin
                    bad  = 1;
                    badi = nb;
                end
                n_chk++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL tx_frame: byte %h got txd=%b at bit %0d expected %b",
                             b, txd, badi, (badi < nb) ? bits[badi] : 1'b1);
                end
                mon_busy = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.cs_i   = 1'b1;
        bus.wr_i   = 1'b1;
        bus.rd_i   = 1'b0;
        bus.addr_i = a;
        bus.data_i = d;
        @(posedge clk);
        #1;
        bus.cs_i = 1'b0;
        bus.wr_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        exp_rd.push_back(e);
        bus.cs_i   = 1'b1;
        bus.rd_i   = 1'b1;
        bus.wr_i   = 1'b0;
        bus.addr_i = a;
        @(posedge clk);
        #1;
        bus.cs_i = 1'b0;
        bus.rd_i = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || mon_busy) && n < maxc) begin
            @(posedge clk);
            n++;
        end
        if (n >= maxc) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d frames pending expected 0",
                     exp_tx.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        int icyc;
        bus.cs_i   = 1'b0;
        bus.wr_i   = 1'b0;
        bus.rd_i   = 1'b0;
        bus.addr_i = '0;
        bus.data_i = '0;
        ack        = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_int", 32'(intr), 32'd0);
        check("rst_rdy", 32'(bus.data_rdy_o), 32'd0);
        rst_n = 1'b1;
        rd(4'h4, 32'h0000_0004);
        rd(4'h8, 32'd139);
        rd(4'hC, 32'd0);

        // reset in the middle of a frame
        mon_en = 0;
        wr(4'h8, 32'd4);
        wr(4'hC, 32'd1);
        wr(4'h0, 32'hC3);
        repeat (10) @(posedge clk);
        #1;
        rd(4'h4, 32'h0000_0005);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_txd_hold", 32'(txd), 32'd1);
        rst_n = 1'b1;
        rd(4'h4, 32'h0000_0004);
        rd(4'h8, 32'd139);
        rd(4'hC, 32'd0);
        mon_en = 1;

        // 0x55 at 4 cycles/bit
        tb_div = 4;
        tb_par = 0;
        wr(4'h8, 32'd4);
        wr(4'hC, 32'd1);
        exp_tx.push_back(8'h55);
        wr(4'h0, 32'h55);
        wait_idle(200);

        // BAUD 0 behaves as 1
        tb_div = 1;
        wr(4'h8, 32'd0);
        exp_tx.push_back(8'h81);
        wr(4'h0, 32'h81);
        wait_idle(100);
        rd(4'h8, 32'd0);

        // fill past full, then drain
        wr(4'hC, 32'd0);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_tx.push_back(8'h30 + 8'(i));
            wr(4'h0, 32'h30 + 32'(i));
        end
        rd(4'h4, 32'h0000_100A);
        wr(4'h4, 32'h8);
        rd(4'h4, 32'h0000_1002);
        wr(4'h8, 32'd1);
        wr(4'hC, 32'd1);
        wait_idle(1000);
        rd(4'h4, 32'h0000_0004);

        // back-to-back frames and interrupt
        tb_div = 2;
        wr(4'h8, 32'd2);
        start_cyc.delete();
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h0F);
        wr(4'hC, 32'd3);
        wr(4'h0, 32'hA5);
        wr(4'h0, 32'h0F);
        n = 0;
        while (intr !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        icyc = cyc;
        check("int_set", 32'(intr), 32'd1);
        if (start_cyc.size() < 2) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_count: got %0d starts expected 2", start_cyc.size());
        end else begin
            check("frame_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd21);
            check("int_time", 32'(icyc - start_cyc[1]), 32'd20);
        end
        repeat (3) @(negedge clk);
        check("int_hold", 32'(intr), 32'd1);
        @(posedge clk);
        #1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("int_ack", 32'(intr), 32'd0);
        wait_idle(100);

        // read latency, read without select, read-during-write
        rd(4'h8, 32'd2);
        check("lat_rdy1", 32'(bus.data_rdy_o), 32'd1);
        @(posedge clk);
        #1;
        check("lat_rdy0", 32'(bus.data_rdy_o), 32'd0);
        bus.rd_i   = 1'b1;
        bus.addr_i = 4'h8;
        @(posedge clk);
        #1;
        bus.rd_i = 1'b0;
        check("nocs_rdy", 32'(bus.data_rdy_o), 32'd0);
        check("nocs_data", bus.data_o, 32'd0);
        exp_rd.push_back(32'd2);
        bus.cs_i   = 1'b1;
        bus.wr_i   = 1'b1;
        bus.rd_i   = 1'b1;
        bus.addr_i = 4'h8;
        bus.data_i = 32'd7;
        @(posedge clk);
        #1;
        bus.cs_i = 1'b0;
        bus.wr_i = 1'b0;
        bus.rd_i = 1'b0;
        rd(4'h8, 32'd7);

        // parity option
        tb_div = 4;
        wr(4'h8, 32'd4);
`ifdef UART_TX_PARITY_EN
        tb_par = 1;
        wr(4'hC, 32'd5);
        rd(4'hC, 32'd5);
`else
        tb_par = 0;
        wr(4'hC, 32'd5);
        rd(4'hC, 32'd1);
`endif
        exp_tx.push_back(8'h07);
        wr(4'h0, 32'h07);
        wait_idle(200);
        check("int_quiet", 32'(intr), 32'd0);

        repeat (3) @(posedge clk);
        if (exp_rd.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_pending: got %0d reads unanswered expected 0",
                     exp_rd.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
